// File: rtl/hazard_controller_if.sv
// ============================================================================
//  Module      : hazard_controller_if
//  Description : Hazard-information and stage-control bundle between the
//                5-stage pipeline datapath (master) and the hazard
//                controller (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface hazard_controller_if;
  // hazard information from ID, ID/EX, EX/MEM and the data-memory handshake
  logic       i_id_valid;
  logic [4:0] i_id_rs1;
  logic [4:0] i_id_rs2;
  logic       i_id_use_rs1;
  logic       i_id_use_rs2;
  logic       i_id_is_branch;
  logic       i_id_ex_valid;
  logic [4:0] i_id_ex_rd;
  logic       i_id_ex_reg_write;
  logic       i_id_ex_mem_read;
  logic       i_ex_mem_valid;
  logic [4:0] i_ex_mem_rd;
  logic       i_ex_mem_mem_read;
  logic       i_ex_redirect;
  logic       i_id_redirect;
  logic       i_mem_req;
  logic       i_mem_ready;

  // per-stage controls back to the datapath
  logic       o_pc_en;
  logic       o_if_id_en;
  logic       o_if_id_flush;
  logic       o_id_ex_en;
  logic       o_id_ex_flush;
  logic       o_ex_mem_en;
  logic       o_mem_wb_en;
  logic       o_halted;
  logic       o_timeout;

  // datapath side: reports hazards, receives controls
  modport master (
    output i_id_valid, i_id_rs1, i_id_rs2, i_id_use_rs1, i_id_use_rs2,
           i_id_is_branch, i_id_ex_valid, i_id_ex_rd, i_id_ex_reg_write,
           i_id_ex_mem_read, i_ex_mem_valid, i_ex_mem_rd, i_ex_mem_mem_read,
           i_ex_redirect, i_id_redirect, i_mem_req, i_mem_ready,
    input  o_pc_en, o_if_id_en, o_if_id_flush, o_id_ex_en, o_id_ex_flush,
           o_ex_mem_en, o_mem_wb_en, o_halted, o_timeout
  );

  // controller side
  modport slave (
    input  i_id_valid, i_id_rs1, i_id_rs2, i_id_use_rs1, i_id_use_rs2,
           i_id_is_branch, i_id_ex_valid, i_id_ex_rd, i_id_ex_reg_write,
           i_id_ex_mem_read, i_ex_mem_valid, i_ex_mem_rd, i_ex_mem_mem_read,
           i_ex_redirect, i_id_redirect, i_mem_req, i_mem_ready,
    output o_pc_en, o_if_id_en, o_if_id_flush, o_id_ex_en, o_id_ex_flush,
           o_ex_mem_en, o_mem_wb_en, o_halted, o_timeout
  );
endinterface

`default_nettype wire

// File: rtl/hazard_controller.sv
// ============================================================================
//  Module      : hazard_controller
//  Description : Central pipeline sequencer for the 5-stage core. Produces
//                per-stage enable/flush controls, handles reset warm-up,
//                data-memory wait freeze and memory-timeout error.
//                Optional macro HAZARD_PERF_EN adds saturating 32-bit
//                stall and flush event counters.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_controller #(
  parameter int RESET_HOLD  = 4,
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 8
) (
  input  wire logic          i_clk,
  input  wire logic          i_rst_n,
  hazard_controller_if.slave hz
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]        o_stall_count,
  output logic [31:0]        o_flush_count
`endif
);

  localparam logic [1:0] ST_INIT   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_FREEZE = 2'd2;
  localparam logic [1:0] ST_ERROR  = 2'd3;

  // with no warm-up requested the pipeline comes out of reset already running
  localparam logic [1:0] ST_RESET = (RESET_HOLD == 0) ? ST_RUN : ST_INIT;

  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(RESET_HOLD - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(MEM_TIMEOUT);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;

  logic             w_freeze;
  logic             w_match_ex;
  logic             w_match_mem;
  logic             w_load_use;
  logic             w_branch_ex;
  logic             w_branch_mem;
  logic             w_stall;
  logic             w_run_dec;
  logic [CNT_W-1:0] w_cnt_inc;

  // ---------------------------------------------------------------------------
  // Hazard detection: a producer register matches when it is non-zero and is
  // actually read by the ID instruction through rs1 or rs2.
  // ---------------------------------------------------------------------------
  assign w_match_ex  = (hz.i_id_ex_rd != 5'd0) &&
                       ((hz.i_id_use_rs1 && (hz.i_id_ex_rd == hz.i_id_rs1)) ||
                        (hz.i_id_use_rs2 && (hz.i_id_ex_rd == hz.i_id_rs2)));
  assign w_match_mem = (hz.i_ex_mem_rd != 5'd0) &&
                       ((hz.i_id_use_rs1 && (hz.i_ex_mem_rd == hz.i_id_rs1)) ||
                        (hz.i_id_use_rs2 && (hz.i_ex_mem_rd == hz.i_id_rs2)));

  // load data is not forwardable into EX; branches compare in ID so they also
  // need ALU results from EX and load results from MEM to be written back first
  assign w_load_use   = hz.i_id_ex_valid & hz.i_id_ex_mem_read & w_match_ex;
  assign w_branch_ex  = hz.i_id_is_branch & hz.i_id_ex_valid &
                        hz.i_id_ex_reg_write & w_match_ex;
  assign w_branch_mem = hz.i_id_is_branch & hz.i_ex_mem_valid &
                        hz.i_ex_mem_mem_read & w_match_mem;
  assign w_stall      = hz.i_id_valid & (w_load_use | w_branch_ex | w_branch_mem);

  assign w_freeze  = hz.i_mem_req & ~hz.i_mem_ready;
  assign w_cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;

  // RUN decode applies in RUN without a pending wait, and in the FREEZE cycle
  // where memory completes (freeze is treated as already released)
  assign w_run_dec = ((state_q == ST_RUN) & ~w_freeze) |
                     ((state_q == ST_FREEZE) & hz.i_mem_ready);

  // State, counter and sticky timeout registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= ST_RESET;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  // Next-state, counter and timeout flag computation
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
    case (state_q)
      ST_INIT: begin
        if (cnt_q == HOLD_LAST) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = w_cnt_inc;
        end
      end
      ST_RUN: begin
        if (w_freeze) begin
          // this cycle is already the first freeze cycle
          cnt_d   = CNT_W'(1);
          state_d = (MEM_TIMEOUT == 1) ? ST_ERROR : ST_FREEZE;
        end
      end
      ST_FREEZE: begin
        if (hz.i_mem_ready) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = w_cnt_inc;
          if ((MEM_TIMEOUT != 0) && (w_cnt_inc >= TIMEOUT_VAL)) begin
            state_d = ST_ERROR;
          end
        end
      end
      ST_ERROR: begin
        state_d = ST_ERROR;
      end
      default: begin
        state_d = ST_RESET;
        cnt_d   = '0;
      end
    endcase
    if (state_d == ST_ERROR) begin
      timeout_d = 1'b1;
    end
  end

  // Stage control decode from current state and hazard priority
  always_comb begin
    hz.o_pc_en       = 1'b0;
    hz.o_if_id_en    = 1'b0;
    hz.o_if_id_flush = 1'b0;
    hz.o_id_ex_en    = 1'b0;
    hz.o_id_ex_flush = 1'b0;
    hz.o_ex_mem_en   = 1'b0;
    hz.o_mem_wb_en   = 1'b0;
    hz.o_halted      = 1'b0;
    if (state_q == ST_INIT) begin
      hz.o_if_id_flush = 1'b1;
      hz.o_id_ex_flush = 1'b1;
      hz.o_halted      = 1'b1;
    end else if (state_q == ST_ERROR) begin
      hz.o_halted = 1'b1;
    end else if (w_run_dec) begin
      hz.o_pc_en     = 1'b1;
      hz.o_if_id_en  = 1'b1;
      hz.o_id_ex_en  = 1'b1;
      hz.o_ex_mem_en = 1'b1;
      hz.o_mem_wb_en = 1'b1;
      if (hz.i_ex_redirect) begin
        // the stalled ID instruction is wrong-path, so the redirect wins
        hz.o_if_id_flush = 1'b1;
        hz.o_id_ex_flush = 1'b1;
      end else if (w_stall) begin
        // hold IF and ID, insert a bubble into EX; ID redirect is not trusted
        hz.o_pc_en       = 1'b0;
        hz.o_if_id_en    = 1'b0;
        hz.o_id_ex_flush = 1'b1;
      end else if (hz.i_id_redirect) begin
        hz.o_if_id_flush = 1'b1;
      end
    end
    // FREEZE without ready: everything holds, redirects stay in their stages
  end

  assign hz.o_timeout = timeout_q;

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_count_q, stall_count_d;
  logic [31:0] flush_count_q, flush_count_d;

  // Saturating event counters for RUN-decoded stalls and IF/ID flushes
  always_comb begin
    stall_count_d = stall_count_q;
    flush_count_d = flush_count_q;
    if (w_run_dec && !hz.i_ex_redirect && w_stall &&
        (stall_count_q != 32'hFFFF_FFFF)) begin
      stall_count_d = stall_count_q + 32'd1;
    end
    if (w_run_dec && hz.o_if_id_flush && (flush_count_q != 32'hFFFF_FFFF)) begin
      flush_count_d = flush_count_q + 32'd1;
    end
  end

  // Counter registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      stall_count_q <= 32'd0;
      flush_count_q <= 32'd0;
    end else begin
      stall_count_q <= stall_count_d;
      flush_count_q <= flush_count_d;
    end
  end

  assign o_stall_count = stall_count_q;
  assign o_flush_count = flush_count_q;
`endif

endmodule

`default_nettype wire

// File: doc/hazard_controller.md
Name: hazard_controller

Overview:
Central pipeline sequencer for the 5-stage core (IF/ID/EX/MEM/WB).
- Consumes hazard information from ID, ID/EX, EX/MEM and the data-memory handshake.
- Drives per-stage enable, flush and bubble controls.
- Owns reset warm-up, memory-wait freeze and the memory-timeout error state.
- Complements operand forwarding: it stalls only where forwarding cannot resolve the dependency.

Parameters:
- RESET_HOLD, 4, cycles the pipeline is held and flushed after reset release; 0 = go straight to RUN.
- MEM_TIMEOUT, 255, consecutive freeze cycles before entering ERROR; 0 = timeout disabled.
- CNT_W, 8, width of the freeze/hold counter; must hold max(RESET_HOLD, MEM_TIMEOUT).

Ports:
- i_clk  in  1  core clock
- i_rst_n  in  1  reset, asynchronous, active-low
- i_id_valid  in  1  ID holds a valid instruction
- i_id_rs1 / i_id_rs2  in  5  ID source registers
- i_id_use_rs1 / i_id_use_rs2  in  1  ID instruction reads rs1/rs2
- i_id_is_branch  in  1  ID instruction compares operands in ID
- i_id_ex_valid  in  1  ID/EX valid, non-bubble
- i_id_ex_rd  in  5  ID/EX destination
- i_id_ex_reg_write  in  1  ID/EX writes rd
- i_id_ex_mem_read  in  1  ID/EX is a load
- i_ex_mem_valid  in  1  EX/MEM valid, non-bubble
- i_ex_mem_rd  in  5  EX/MEM destination
- i_ex_mem_mem_read  in  1  EX/MEM is a load
- i_ex_redirect  in  1  EX resolved control transfer (jalr/mispredict)
- i_id_redirect  in  1  ID branch resolved taken
- i_mem_req  in  1  MEM stage has outstanding data access
- i_mem_ready  in  1  data memory completes access this cycle
- o_pc_en  out  1  PC update enable
- o_if_id_en  out  1  IF/ID register enable
- o_if_id_flush  out  1  IF/ID loads bubble
- o_id_ex_en  out  1  ID/EX register enable
- o_id_ex_flush  out  1  ID/EX loads bubble
- o_ex_mem_en  out  1  EX/MEM register enable
- o_mem_wb_en  out  1  MEM/WB register enable
- o_halted  out  1  state is INIT or ERROR
- o_timeout  out  1  sticky memory-timeout error

Behaviour:
- Clock and reset: single clock i_clk; reset i_rst_n is asynchronous, active-low.
- Reset values: state = INIT (RUN if RESET_HOLD=0), cnt = 0, o_timeout = 0. Outputs follow the combinational decode below.
- States and transitions:
  - INIT: all *_en = 0, both flushes = 1, o_halted = 1. cnt increments each cycle; at cnt == RESET_HOLD-1, go to RUN and clear cnt.
  - RUN: freeze = i_mem_req & ~i_mem_ready. When freeze = 1, go to FREEZE with cnt = 1, and that cycle's outputs already use FREEZE decode. Otherwise apply the priority decode below.
  - FREEZE: all *_en = 0, flushes = 0; redirects ignored (the frozen stages hold them).
    - i_mem_ready = 1 → RUN, cnt = 0; that same cycle uses RUN decode with freeze forced 0.
    - Else cnt++; if MEM_TIMEOUT != 0 and cnt == MEM_TIMEOUT → ERROR.
  - ERROR: all *_en = 0, flushes = 0, o_timeout = 1, o_halted = 1. Exit only by reset.
- RUN priority decode (highest first):
  1. EX redirect: o_pc_en = 1, o_if_id_flush = 1, o_id_ex_flush = 1, all other enables 1. Overrides any data stall (the stalled instruction is wrong-path).
  2. Data stall, where match(r) = r != 0 & ((i_id_use_rs1 & r == i_id_rs1) | (i_id_use_rs2 & r == i_id_rs2)) and stall is asserted by any of:
     - load-use: i_id_ex_valid & i_id_ex_mem_read & match(i_id_ex_rd)
     - branch-on-EX: i_id_is_branch & i_id_ex_valid & i_id_ex_reg_write & match(i_id_ex_rd)
     - branch-on-load-in-MEM: i_id_is_branch & i_ex_mem_valid & i_ex_mem_mem_read & match(i_ex_mem_rd)
     - Stall is gated by i_id_valid.
     - Effect: o_pc_en = 0, o_if_id_en = 0, o_id_ex_flush = 1, o_id_ex_en = o_ex_mem_en = o_mem_wb_en = 1. i_id_redirect is ignored.
  3. ID redirect: o_if_id_flush = 1, all enables 1.
  4. Otherwise: all enables 1, flushes 0.
- Branch-after-load stalls are consecutive: 2 stall cycles arise naturally from the rules above.
- Reset asserted mid-FREEZE or mid-ERROR returns to INIT immediately and clears o_timeout.

Optional Feature:
- HAZARD_PERF_EN defined: adds o_stall_count (32-bit, out) and o_flush_count (32-bit, out), both reset to 0 and saturating at 0xFFFFFFFF.
  - o_stall_count increments on each RUN data-stall cycle.
  - o_flush_count increments on each cycle with o_if_id_flush = 1 in RUN.
- Undefined: the ports and counters are absent.

Test Plan:
- Reset release, RESET_HOLD=4 → o_halted = 1 and flushes = 1 for exactly 4 cycles; o_pc_en rises on cycle 5.
- Load x5 in ID/EX, ID `add x6,x5,x1` → one cycle with o_pc_en = 0, o_id_ex_flush = 1; next cycle all enables 1.
- Load x7, then `beq x7,x0` in ID → 2 consecutive stall cycles (EX, then MEM), then o_pc_en = 1. A concurrent i_id_redirect is ignored during the stalls.
- Load-use stall plus i_ex_redirect in the same cycle → o_pc_en = 1, o_if_id_flush = 1, o_id_ex_flush = 1.
- i_mem_req = 1, i_mem_ready = 0 for 3 cycles, then 1 → all enables 0 for 3 cycles, normal decode on cycle 4, o_timeout stays 0.
- MEM_TIMEOUT=8, i_mem_ready held 0 → ERROR after 8 freeze cycles; o_timeout = 1 stays set until reset, then clears.
